// File: rtl/iq_pkg.sv
// -----------------------------------------------------------------------------
// iq_pkg
// Shared definitions for the instruction queue:
//   - default parameter values for inst_queue / iq_compact
//   - popcount():  number of set bits in a valid mask
//   - ptr_add():   circular-buffer pointer addition modulo a power-of-2 depth
// -----------------------------------------------------------------------------
package iq_pkg;

    localparam int unsigned IQ_DATA_W = 32;  // instruction width
    localparam int unsigned IQ_IN_W   = 8;   // fetch slots per cycle
    localparam int unsigned IQ_OUT_W  = 4;   // decode slots per cycle
    localparam int unsigned IQ_DEPTH  = 32;  // queue entries (power of 2)

    // Widest valid mask popcount() accepts; callers zero-extend to this width.
    localparam int unsigned IQ_MAX_W  = 64;

    // Number of set bits in a mask.
    function automatic int unsigned popcount(input logic [IQ_MAX_W-1:0] vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < IQ_MAX_W; i++) begin
            if (vec[i]) n++;
        end
        return n;
    endfunction

    // (ptr + inc) mod depth, with depth a power of 2 so the modulo is a mask.
    function automatic int unsigned ptr_add(input int unsigned ptr,
                                            input int unsigned inc,
                                            input int unsigned depth);
        return (ptr + inc) & (depth - 1);
    endfunction

endpackage

// File: rtl/iq_compact.sv
// -----------------------------------------------------------------------------
// iq_compact
// Squeezes a sparse fetch bundle into a dense one: output slot m carries the
// m-th valid input slot (ascending slot order). Output slots at or above
// o_push_n are driven to 0.
//
// Ports:
//   i_vld     [IN_W]          per-slot valid of the incoming bundle
//   i_inst    [IN_W*DATA_W]   incoming bundle, slot k = [k*DATA_W +: DATA_W]
//   o_inst    [IN_W*DATA_W]   compacted bundle, slot m = m-th valid instruction
//   o_push_n  [clog2(IN_W+1)] number of valid input slots
// -----------------------------------------------------------------------------
module iq_compact
    import iq_pkg::*;
#(
    parameter int unsigned IN_W   = IQ_IN_W,
    parameter int unsigned DATA_W = IQ_DATA_W
) (
    input  logic [IN_W-1:0]           i_vld,
    input  logic [IN_W*DATA_W-1:0]    i_inst,
    output logic [IN_W*DATA_W-1:0]    o_inst,
    output logic [$clog2(IN_W+1)-1:0] o_push_n
);

    localparam int unsigned PN_W = $clog2(IN_W + 1);

    // Exclusive prefix popcount: w_prefix[k] = number of valid slots below k,
    // i.e. the compacted position slot k lands on when it is valid.
    logic [PN_W-1:0] w_prefix [IN_W];

    // NOTE: combinational blocks assign every output a default first so that no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        logic [PN_W-1:0] w_acc;
        w_acc = '0;
        for (int k = 0; k < IN_W; k++) begin
            w_prefix[k] = w_acc;
            w_acc       = w_acc + PN_W'(i_vld[k]);
        end
    end

    // Output slot m selects the unique valid input whose prefix equals m.
    // Input k can only land at position <= k, so the inner loop starts at m.
    always_comb begin
        o_inst = '0;
        for (int m = 0; m < IN_W; m++) begin
            for (int k = m; k < IN_W; k++) begin
                if (i_vld[k] && (w_prefix[k] == PN_W'(m))) begin
                    o_inst[m*DATA_W +: DATA_W] = i_inst[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign o_push_n = PN_W'(popcount(IQ_MAX_W'(i_vld)));

endmodule

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
// Decoupling queue between fetch and decode. Accepts up to IN_W instructions
// per cycle under an arbitrary valid mask, compacts them into a DEPTH-entry
// circular buffer, and presents up to OUT_W oldest entries to decode.
//
// Ports:
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   flush_i     discard all entries; same-cycle push/pop are ignored
//   fe_vld_i    [IN_W]           per-slot valid of the fetch bundle
//   fe_inst_i   [IN_W*DATA_W]    fetch bundle, slot k = [k*DATA_W +: DATA_W]
//   fe_rdy_o    a whole bundle fits (free entries >= IN_W)
//   dec_inst_o  [OUT_W*DATA_W]   oldest entries, slot 0 oldest, 0 when invalid
//   dec_vld_o   [OUT_W]          thermometer valid from bit 0
//   dec_rdy_i   decode takes every slot flagged in dec_vld_o
//   count_o     [clog2(DEPTH+1)] occupancy
//   full_o      ~fe_rdy_o
//   empty_o     occupancy is zero
//
// Pushed entries appear on dec_inst_o the cycle after the push; there is no
// empty-queue bypass. Acceptance is decided on the pre-pop occupancy.
// -----------------------------------------------------------------------------
module inst_queue
    import iq_pkg::*;
#(
    parameter int unsigned DATA_W = IQ_DATA_W,
    parameter int unsigned IN_W   = IQ_IN_W,
    parameter int unsigned OUT_W  = IQ_OUT_W,
    parameter int unsigned DEPTH  = IQ_DEPTH
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        flush_i,
    input  logic [IN_W-1:0]             fe_vld_i,
    input  logic [IN_W*DATA_W-1:0]      fe_inst_i,
    output logic                        fe_rdy_o,
    output logic [OUT_W*DATA_W-1:0]     dec_inst_o,
    output logic [OUT_W-1:0]            dec_vld_o,
    input  logic                        dec_rdy_i,
    output logic [$clog2(DEPTH+1)-1:0]  count_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PN_W  = $clog2(IN_W + 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // ------------------------------------------------------------------------
    // Compaction of the fetch bundle
    // ------------------------------------------------------------------------
    logic [IN_W*DATA_W-1:0] w_comp_inst;
    logic [PN_W-1:0]        w_bundle_n;

    iq_compact #(
        .IN_W   (IN_W),
        .DATA_W (DATA_W)
    ) u_compact (
        .i_vld    (fe_vld_i),
        .i_inst   (fe_inst_i),
        .o_inst   (w_comp_inst),
        .o_push_n (w_bundle_n)
    );

    // ------------------------------------------------------------------------
    // Handshake and occupancy arithmetic
    // ------------------------------------------------------------------------
    logic             w_fe_rdy;
    logic             w_push;
    logic [CNT_W-1:0] w_push_n;
    logic [CNT_W-1:0] w_avail;
    logic [CNT_W-1:0] w_pop_n;
    logic [CNT_W-1:0] w_count_next;

    // Ready looks only at the registered count, so it is a clean function of
    // state and never loops back through fetch or decode handshakes.
    assign w_fe_rdy = (r_count <= CNT_W'(DEPTH - IN_W));
    assign w_push   = w_fe_rdy && (|fe_vld_i) && !flush_i;
    assign w_push_n = w_push ? CNT_W'(w_bundle_n) : '0;

    assign w_avail  = (r_count < CNT_W'(OUT_W)) ? r_count : CNT_W'(OUT_W);
    assign w_pop_n  = (dec_rdy_i && !flush_i) ? w_avail : '0;

    assign w_count_next = r_count + w_push_n - w_pop_n;

    // ------------------------------------------------------------------------
    // Decode-side view: up to OUT_W oldest entries, zeros in invalid slots
    // ------------------------------------------------------------------------
    always_comb begin
        dec_vld_o  = '0;
        dec_inst_o = '0;
        for (int j = 0; j < OUT_W; j++) begin
            if (CNT_W'(j) < w_avail) begin
                dec_vld_o[j] = 1'b1;
                dec_inst_o[j*DATA_W +: DATA_W] =
                    r_mem[PTR_W'(ptr_add(32'(r_rd_ptr), j, DEPTH))];
            end
        end
    end

    assign fe_rdy_o = w_fe_rdy;
    assign full_o   = !w_fe_rdy;
    assign empty_o  = (r_count == '0);
    assign count_o  = r_count;

    // ------------------------------------------------------------------------
    // Storage write. Compacted slot m goes to entry wr_ptr+m; only free
    // entries are ever targeted, so a stale entry is never read.
    // ------------------------------------------------------------------------
    // NOTE: the storage array deliberately has no reset term: an entry is only
    // read after it has been written, and leaving it unreset lets it map onto
    // plain flops or RAM without a reset fan-out.
    always_ff @(posedge clock) begin
        for (int m = 0; m < IN_W; m++) begin
            if (w_push && (PN_W'(m) < w_bundle_n)) begin
                r_mem[PTR_W'(ptr_add(32'(r_wr_ptr), m, DEPTH))] <=
                    w_comp_inst[m*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pointers and count. Flush outranks push and pop.
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= PTR_W'(ptr_add(32'(r_wr_ptr), 32'(w_push_n), DEPTH));
            r_rd_ptr <= PTR_W'(ptr_add(32'(r_rd_ptr), 32'(w_pop_n), DEPTH));
            r_count  <= w_count_next;
        end
    end

    // ------------------------------------------------------------------------
    // Occupancy must stay within 0..DEPTH.
    // ------------------------------------------------------------------------
    logic [CNT_W:0] w_count_sum;
    assign w_count_sum = {1'b0, r_count} + {1'b0, w_push_n};

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        w_count_sum <= (CNT_W+1)'(DEPTH));

    a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
        w_pop_n <= r_count);

endmodule

// File: tb/tb_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_queue
// Directed stimulus for inst_queue. The driver pushes every instruction it
// expects the queue to accept onto a scoreboard; a negedge monitor pops and
// compares whenever decode takes valid slots. Directed checks on count, valid
// and flag outputs use hand-computed constants.
// -----------------------------------------------------------------------------
module tb_inst_queue;

    localparam int DATA_W = 32;
    localparam int IN_W   = 8;
    localparam int OUT_W  = 4;
    localparam int DEPTH  = 32;

    logic                       clock     = 1'b0;
    logic                       reset_n   = 1'b1;
    logic                       flush_i   = 1'b0;
    logic                       dec_rdy_i = 1'b0;
    logic [IN_W-1:0]            fe_vld_i  = '0;
    logic [IN_W*DATA_W-1:0]     fe_inst_i = '0;
    logic                       fe_rdy_o;
    logic [OUT_W*DATA_W-1:0]    dec_inst_o;
    logic [OUT_W-1:0]           dec_vld_o;
    logic [$clog2(DEPTH+1)-1:0] count_o;
    logic                       full_o;
    logic                       empty_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] sb[$];   // expected decode order
    int                m_count = 0;

    inst_queue #(
        .DATA_W (DATA_W),
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush_i    (flush_i),
        .fe_vld_i   (fe_vld_i),
        .fe_inst_i  (fe_inst_i),
        .fe_rdy_o   (fe_rdy_o),
        .dec_inst_o (dec_inst_o),
        .dec_vld_o  (dec_vld_o),
        .dec_rdy_i  (dec_rdy_i),
        .count_o    (count_o),
        .full_o     (full_o),
        .empty_o    (empty_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] slot(input int j);
        return dec_inst_o[j*DATA_W +: DATA_W];
    endfunction

    // Apply one cycle of stimulus (inputs set at posedge+1), record what the
    // queue should accept, then advance to just after the next rising edge.
    task automatic drive(input logic [IN_W-1:0] vld, input logic [DATA_W-1:0] base,
                         input logic rdy, input logic fl);
        int pop_n;
        fe_vld_i  = vld;
        dec_rdy_i = rdy;
        flush_i   = fl;
        for (int k = 0; k < IN_W; k++) fe_inst_i[k*DATA_W +: DATA_W] = base + DATA_W'(k);
        if (fl) begin
            sb.delete();
            m_count = 0;
        end else begin
            pop_n = rdy ? ((m_count < OUT_W) ? m_count : OUT_W) : 0;
            if ((DEPTH - m_count) >= IN_W) begin
                for (int k = 0; k < IN_W; k++) begin
                    if (vld[k]) begin
                        sb.push_back(base + DATA_W'(k));
                        m_count++;
                    end
                end
            end
            m_count -= pop_n;
        end
        @(posedge clock);
        #1;
    endtask

    // Monitor: decode consumes at the next rising edge whenever rdy is high.
    always @(negedge clock) begin
        if (reset_n) begin
            for (int j = 0; j < OUT_W; j++) begin
                if (!dec_vld_o[j]) begin
                    check($sformatf("idle_slot%0d_zero", j), 64'(slot(j)), 64'(0));
                end else if (dec_rdy_i && !flush_i) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_underflow: slot %0d valid with 0x%0h, nothing expected", j, slot(j));
                    end else begin
                        check($sformatf("pop_slot%0d", j), 64'(slot(j)), 64'(sb.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        // ---------------- reset ----------------
        #1 reset_n = 1'b0;
        #1;
        check("rst_count",  64'(count_o),   64'(0));
        check("rst_vld",    64'(dec_vld_o), 64'(0));
        check("rst_empty",  64'(empty_o),   64'(1));
        check("rst_full",   64'(full_o),    64'(0));
        check("rst_fe_rdy", 64'(fe_rdy_o),  64'(1));
        @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b1;

        // ---------------- full bundle, drained over two pops ----------------
        drive(8'hFF, 32'h100, 1'b1, 1'b0);
        check("t1_count", 64'(count_o),   64'(8));
        check("t1_vld",   64'(dec_vld_o), 64'(4'hF));
        check("t1_s0",    64'(slot(0)),   64'(32'h100));
        check("t1_s3",    64'(slot(3)),   64'(32'h103));
        drive(8'h00, 32'h0, 1'b1, 1'b0);
        check("t1_count2", 64'(count_o), 64'(4));
        check("t1_s0b",    64'(slot(0)), 64'(32'h104));
        check("t1_s3b",    64'(slot(3)), 64'(32'h107));
        drive(8'h00, 32'h0, 1'b1, 1'b0);
        check("t1_empty", 64'(empty_o), 64'(1));
        check("t1_count3", 64'(count_o), 64'(0));

        // ---------------- sparse mask compaction ----------------
        drive(8'hA5, 32'h200, 1'b0, 1'b0);
        check("t2_count", 64'(count_o),   64'(4));
        check("t2_vld",   64'(dec_vld_o), 64'(4'hF));
        check("t2_s0",    64'(slot(0)),   64'(32'h200));
        check("t2_s1",    64'(slot(1)),   64'(32'h202));
        check("t2_s2",    64'(slot(2)),   64'(32'h205));
        check("t2_s3",    64'(slot(3)),   64'(32'h207));
        drive(8'h00, 32'h0, 1'b1, 1'b0);
        check("t2_count2", 64'(count_o), 64'(0));

        // ---------------- partial issue ----------------
        drive(8'h07, 32'h300, 1'b1, 1'b0);
        check("t3_vld",   64'(dec_vld_o), 64'(4'b0111));
        check("t3_count", 64'(count_o),   64'(3));
        check("t3_s2",    64'(slot(2)),   64'(32'h302));
        drive(8'h00, 32'h0, 1'b1, 1'b0);
        check("t3_count2", 64'(count_o),   64'(0));
        check("t3_vld2",   64'(dec_vld_o), 64'(0));

        // ---------------- full and backpressure ----------------
        for (int i = 0; i < 3; i++) drive(8'hFF, 32'h400 + 32'(16*i), 1'b0, 1'b0);
        check("t4_count24", 64'(count_o),  64'(24));
        check("t4_rdy24",   64'(fe_rdy_o), 64'(1));
        check("t4_full24",  64'(full_o),   64'(0));
        drive(8'hFF, 32'h430, 1'b0, 1'b0);
        check("t4_count32", 64'(count_o),  64'(32));
        check("t4_rdy32",   64'(fe_rdy_o), 64'(0));
        check("t4_full32",  64'(full_o),   64'(1));
        drive(8'hFF, 32'h440, 1'b0, 1'b0);
        check("t4_ignored", 64'(count_o),  64'(32));
        drive(8'h00, 32'h0, 1'b1, 1'b0);
        check("t4_count28", 64'(count_o),  64'(28));
        check("t4_full28",  64'(full_o),   64'(1));
        drive(8'h00, 32'h0, 1'b1, 1'b0);
        check("t4_count24b", 64'(count_o),  64'(24));
        check("t4_rdy24b",   64'(fe_rdy_o), 64'(1));
        repeat (6) drive(8'h00, 32'h0, 1'b1, 1'b0);
        check("t4_drained", 64'(count_o), 64'(0));

        // ---------------- wrap-around: move pointers to 28 ----------------
        drive(8'hFF, 32'hA00, 1'b0, 1'b0);
        drive(8'h1F, 32'hA10, 1'b0, 1'b0);
        check("t5_prep13", 64'(count_o), 64'(13));
        repeat (4) drive(8'h00, 32'h0, 1'b1, 1'b0);
        check("t5_prep0", 64'(count_o), 64'(0));
        drive(8'hFF, 32'h500, 1'b0, 1'b0);
        check("t5_count", 64'(count_o), 64'(8));
        check("t5_s0",    64'(slot(0)), 64'(32'h500));
        check("t5_s3",    64'(slot(3)), 64'(32'h503));
        drive(8'h00, 32'h0, 1'b1, 1'b0);
        check("t5_count2", 64'(count_o), 64'(4));
        check("t5_s0b",    64'(slot(0)), 64'(32'h504));
        check("t5_s3b",    64'(slot(3)), 64'(32'h507));
        drive(8'h00, 32'h0, 1'b1, 1'b0);
        check("t5_count3", 64'(count_o), 64'(0));

        // ---------------- flush with concurrent push and pop ----------------
        drive(8'hFF, 32'h600, 1'b0, 1'b0);
        drive(8'h0F, 32'h610, 1'b0, 1'b0);
        check("t6_count12", 64'(count_o), 64'(12));
        drive(8'hFF, 32'h620, 1'b1, 1'b1);
        check("t6_count", 64'(count_o),   64'(0));
        check("t6_vld",   64'(dec_vld_o), 64'(0));
        check("t6_empty", 64'(empty_o),   64'(1));
        check("t6_rdy",   64'(fe_rdy_o),  64'(1));
        drive(8'h0F, 32'h700, 1'b0, 1'b0);
        check("t6_count4", 64'(count_o), 64'(4));
        check("t6_s0",     64'(slot(0)), 64'(32'h700));
        check("t6_s3",     64'(slot(3)), 64'(32'h703));
        drive(8'h00, 32'h0, 1'b1, 1'b0);
        check("t6_count0", 64'(count_o), 64'(0));

        // ---------------- asynchronous reset mid-stream ----------------
        drive(8'hFF, 32'h800, 1'b0, 1'b0);
        check("t7_count8", 64'(count_o), 64'(8));
        fe_vld_i  = '0;
        dec_rdy_i = 1'b0;
        #2 reset_n = 1'b0;
        sb.delete();
        m_count = 0;
        #1;
        check("t7_rst_count", 64'(count_o),   64'(0));
        check("t7_rst_vld",   64'(dec_vld_o), 64'(0));
        check("t7_rst_empty", 64'(empty_o),   64'(1));
        check("t7_rst_full",  64'(full_o),    64'(0));
        check("t7_rst_rdy",   64'(fe_rdy_o),  64'(1));
        @(posedge clock);
        #1 reset_n = 1'b1;
        drive(8'h03, 32'h900, 1'b0, 1'b0);
        check("t7_count2", 64'(count_o),   64'(2));
        check("t7_vld",    64'(dec_vld_o), 64'(4'b0011));
        check("t7_s0",     64'(slot(0)),   64'(32'h900));
        check("t7_s1",     64'(slot(1)),   64'(32'h901));
        drive(8'h00, 32'h0, 1'b1, 1'b0);
        check("t7_count0", 64'(count_o), 64'(0));

        // ---------------- wrap up ----------------
        drive(8'h00, 32'h0, 1'b0, 1'b0);
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
